// File: rtl/j_mwalk_pkg.sv
// j_mwalk_pkg: shared state encodings and width helpers for the matrix walker.
package j_mwalk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } mw_state_e;

    localparam logic [4:0] MW_ZERO_WIDTH = 5'd16;

    // A width field of 0 encodes a full 16-element row/column.
    function automatic logic [4:0] mw_elems(input logic [3:0] w);
        return (w == 4'd0) ? MW_ZERO_WIDTH : {1'b0, w};
    endfunction

endpackage

// File: rtl/j_mwalk_count.sv
// j_mwcount: 5-bit load/decrement element counter with count==1 detect.
module j_mwcount
    import j_mwalk_pkg::*;
(
    input  logic       sys_clk,
    input  logic       resetl,
    input  logic       load,
    input  logic       en,
    input  logic [4:0] load_val,
    output logic       count1
);

    logic [4:0] count_q, count_d;

    always_comb begin
        count_d = load ? load_val : en ? count_q - 5'd1 : count_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count1 = (count_q == 5'd1);

endmodule

// File: rtl/j_mwalk.sv
// j_mwalk: issues one read per matrix element along a row or column, holding each request until acknowledged.
module j_mwalk
    import j_mwalk_pkg::*;
(
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        start,
    input  logic [21:0] mtxa,
    input  logic [3:0]  mwidth,
    input  logic        maddw,
    input  logic        rd_ack,
    output logic        rd_req,
    output logic [21:0] rd_addr,
    output logic        first,
    output logic        last,
    output logic        busy,
    output logic        done
);

    mw_state_e   state_q, state_d;
    logic [21:0] addr_q, addr_d;
    logic [4:0]  stride_q, stride_d;
    logic        first_q, first_d;
    logic        cnt_load, cnt_en, count1;

    j_mwcount u_count (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (mw_elems(mwidth)),
        .count1   (count1)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        first_d  = first_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                addr_d   = mtxa;
                stride_d = maddw ? mw_elems(mwidth) : 5'd1;
                first_d  = 1'b1;
                cnt_load = 1'b1;
                state_d  = ISSUE;
            end
            ISSUE: if (rd_ack) begin
                first_d = 1'b0;
                // The final element leaves the address parked on itself.
                if (count1) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + {17'd0, stride_q};
                    cnt_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            first_q  <= first_d;
        end
    end

    assign rd_req  = (state_q == ISSUE);
    assign rd_addr = addr_q;
    assign first   = rd_req & first_q;
    assign last    = rd_req & count1;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_j_mwalk.sv
// tb_j_mwalk: table-driven walks checked against a queue of expected requests, plus reset corner cases.
module tb_j_mwalk;

    logic        sys_clk = 1'b0;
    logic        resetl  = 1'b0;
    logic        start   = 1'b0;
    logic [21:0] mtxa    = '0;
    logic [3:0]  mwidth  = '0;
    logic        maddw   = 1'b0;
    logic        rd_ack  = 1'b0;
    logic        rd_req, first, last, busy, done;
    logic [21:0] rd_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [21:0] addr;
        logic        first;
        logic        last;
    } exp_t;

    typedef struct {
        logic [21:0] base;
        logic [3:0]  w;
        logic        mode;
        int          dly;
        bit          inj;
        int          exp_n;
        logic [21:0] exp_stride;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    j_mwalk dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .start   (start),
        .mtxa    (mtxa),
        .mwidth  (mwidth),
        .maddw   (maddw),
        .rd_ack  (rd_ack),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .first   (first),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_walk(input vec_t v);
        int waitc = 0;
        int pos = 0;
        int budget = 200;
        for (int i = 0; i < v.exp_n; i++)
            sb.push_back('{addr: v.base + 22'(i) * v.exp_stride,
                           first: (i == 0), last: (i == v.exp_n - 1)});
        mtxa = v.base; mwidth = v.w; maddw = v.mode; start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_req_latency", rd_req, 1);
        while (sb.size() > 0 && budget > 0) begin
            budget--;
            chk("rd_req", rd_req, 1);
            chk("rd_addr", rd_addr, sb[0].addr);
            chk("first", first, sb[0].first);
            chk("last", last, sb[0].last);
            chk("no_early_done", done, 0);
            if (waitc < v.dly) begin
                rd_ack = 1'b0;
                waitc++;
            end else begin
                rd_ack = 1'b1;
                waitc = 0;
                sb.delete(0);
            end
            start = v.inj && (pos == 1);
            if (start) begin
                mtxa = 22'h2AAAAA; mwidth = 4'd7; maddw = ~v.mode;
            end
            pos++;
            tick();
        end
        rd_ack = 1'b0;
        start  = 1'b0;
        if (sb.size() > 0) begin
            chk("walk_timeout_left", sb.size(), 0);
            sb.delete();
        end
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        chk("req_dropped", rd_req, 0);
        start = v.inj;
        if (start) begin
            mtxa = 22'h155555; mwidth = 4'd2;
        end
        tick();
        start = 1'b0;
        chk("done_once", done, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("no_second_walk", rd_req, 0);
    endtask

    initial begin
        vecs[0] = '{base: 22'h000100, w: 4'd4, mode: 1'b0, dly: 0, inj: 1'b0, exp_n: 4,  exp_stride: 22'd1};
        vecs[1] = '{base: 22'h000200, w: 4'd3, mode: 1'b1, dly: 2, inj: 1'b0, exp_n: 3,  exp_stride: 22'd3};
        vecs[2] = '{base: 22'h000000, w: 4'd0, mode: 1'b0, dly: 0, inj: 1'b0, exp_n: 16, exp_stride: 22'd1};
        vecs[3] = '{base: 22'h012345, w: 4'd1, mode: 1'b0, dly: 1, inj: 1'b0, exp_n: 1,  exp_stride: 22'd1};
        vecs[4] = '{base: 22'h3FFFFE, w: 4'd4, mode: 1'b0, dly: 0, inj: 1'b0, exp_n: 4,  exp_stride: 22'd1};
        vecs[5] = '{base: 22'h3FFFF0, w: 4'd0, mode: 1'b1, dly: 1, inj: 1'b0, exp_n: 16, exp_stride: 22'd16};
        vecs[6] = '{base: 22'h000300, w: 4'd5, mode: 1'b0, dly: 1, inj: 1'b1, exp_n: 5,  exp_stride: 22'd1};

        tick();
        tick();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_first", first, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetl = 1'b1;
        tick();
        chk("idle_after_rst", rd_req, 0);

        for (int i = 0; i < 7; i++) run_walk(vecs[i]);

        mtxa = 22'h000400; mwidth = 4'd8; maddw = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; rd_ack = 1'b1;
        chk("mid_rst_addr0", rd_addr, 22'h000400);
        tick();
        chk("mid_rst_addr1", rd_addr, 22'h000401);
        tick();
        chk("mid_rst_addr2", rd_addr, 22'h000402);
        resetl = 1'b0; rd_ack = 1'b0;
        tick();
        chk("mid_rst_rd_req", rd_req, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_first", first, 0);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        resetl = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle_req", rd_req, 0);
            chk("post_rst_no_done", done, 0);
        end
        run_walk(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
